// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared CIC width function and parameter range limits.
package cic_pkg;

  localparam int IN_W_MIN  = 4;
  localparam int IN_W_MAX  = 24;
  localparam int OUT_W_MIN = 4;
  localparam int OUT_W_MAX = 32;
  localparam int N_MIN     = 1;
  localparam int N_MAX     = 6;
  localparam int R_MIN     = 2;
  localparam int R_MAX     = 256;
  localparam int M_MIN     = 1;
  localparam int M_MAX     = 2;

  // Bit growth of an N-stage CIC is N*log2(R*M); sizing to that keeps the
  // modulo-2^ACC_W integrator wrap harmless after the combs.
  function automatic int acc_width(input int in_w, input int n, input int r, input int m);
    return in_w + n * $clog2(r * m);
  endfunction

  function automatic bit params_ok(input int in_w, input int out_w, input int n,
                                   input int r, input int m);
    return (in_w >= IN_W_MIN) && (in_w <= IN_W_MAX) &&
           (out_w >= OUT_W_MIN) && (out_w <= OUT_W_MAX) &&
           (n >= N_MIN) && (n <= N_MAX) &&
           (r >= R_MIN) && (r <= R_MAX) &&
           (m >= M_MIN) && (m <= M_MAX);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// rtl/cic_comb_stage.sv - one CIC comb: out = in - in delayed by M decimated samples.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int ACC_W = 20,
  parameter int M     = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_en,
  input  logic signed [ACC_W-1:0] i_data,
  output logic signed [ACC_W-1:0] o_data
);

  logic signed [ACC_W-1:0] dly [0:M-1];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < M; i++) dly[i] <= '0;
    end else if (i_en) begin
      dly[0] <= i_data;
      for (int i = 1; i < M; i++) dly[i] <= dly[i-1];
    end
  end

  assign o_data = i_data - dly[M-1];

endmodule

// File: rtl/cic_decimator.sv
// rtl/cic_decimator.sv - N-stage CIC decimator (integrators inline, combs as sub-modules).
// Optional macro CIC_OUT_ROUND_EN selects round-half-up with positive saturation on output.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int OUT_W = 20,
  parameter int N     = 2,
  parameter int R     = 16,
  parameter int M     = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic signed [IN_W-1:0]  i_data,
  output logic                    o_valid,
  output logic signed [OUT_W-1:0] o_data
);

  localparam int ACC_W = acc_width(IN_W, N, R, M);
  localparam int CNT_W = $clog2(R);

  if (!params_ok(IN_W, OUT_W, N, R, M)) begin : g_param_check
    $error("cic_decimator: parameter out of range");
  end

  // stage[0] is the input register, stage[k] is integrator k.
  logic signed [ACC_W-1:0] stage [0:N];
  logic [CNT_W-1:0]        dec_cnt;
  logic                    dec_stb;
  logic signed [ACC_W-1:0] comb [0:N];
  logic signed [OUT_W-1:0] scaled;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k <= N; k++) stage[k] <= '0;
    end else if (i_valid) begin
      stage[0] <= {{(ACC_W-IN_W){i_data[IN_W-1]}}, i_data};
      for (int k = 1; k <= N; k++) stage[k] <= stage[k] + stage[k-1];
    end
  end

  assign dec_stb = i_valid && (dec_cnt == CNT_W'(R - 1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      dec_cnt <= '0;
    end else if (i_valid) begin
      dec_cnt <= dec_stb ? '0 : dec_cnt + CNT_W'(1);
    end
  end

  assign comb[0] = stage[N];

  for (genvar k = 1; k <= N; k++) begin : g_comb
    cic_comb_stage #(
      .ACC_W (ACC_W),
      .M     (M)
    ) u_comb (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_en    (dec_stb),
      .i_data  (comb[k-1]),
      .o_data  (comb[k])
    );
  end

  if (OUT_W >= ACC_W) begin : g_sext
    assign scaled = OUT_W'(comb[N]);
  end else begin : g_narrow
    localparam int SHIFT = ACC_W - OUT_W;
`ifdef CIC_OUT_ROUND_EN
    // Adding half an output LSB then truncating equals adding the first
    // discarded bit to the kept bits; only a positive overflow is possible.
    logic [OUT_W:0] rnd;
    assign rnd = {comb[N][ACC_W-1], comb[N][ACC_W-1:SHIFT]} + (OUT_W+1)'(comb[N][SHIFT-1]);
    assign scaled = (rnd[OUT_W] != rnd[OUT_W-1]) ? {1'b0, {(OUT_W-1){1'b1}}}
                                                 : rnd[OUT_W-1:0];
`else
    assign scaled = comb[N][ACC_W-1:SHIFT];
`endif
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= dec_stb;
      if (dec_stb) o_data <= scaled;
    end
  end

endmodule
